// File: rtl/fast_corner_detect.sv
// FAST segment-test corner detector: raster-scans the blurred image in SRAM and
// streams corner coordinates. Optional corner strength score under FAST_SCORE_EN.
module fast_corner_detect #(
   parameter int X_MAX       = 16,
   parameter int Y_MAX       = 16,
   parameter int PIXEL_DEPTH = 8,
   parameter int ARC_LEN     = 9,
   localparam int XW = $clog2(X_MAX),
   localparam int YW = $clog2(Y_MAX),
   localparam int SW = PIXEL_DEPTH + 4
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   new_trans,
   input  logic [XW-1:0]          max_x,
   input  logic [YW-1:0]          max_y,
   input  logic [PIXEL_DEPTH-1:0] threshold,
   output logic [XW:0]            x_addr,
   output logic [YW:0]            y_addr,
   output logic                   ren,
   input  logic [PIXEL_DEPTH-1:0] rdat,
   output logic                   corner_valid,
   input  logic                   corner_ready,
   output logic [XW-1:0]          corner_x,
   output logic [YW-1:0]          corner_y,
   output logic [SW-1:0]          corner_score,
   output logic                   fast_done
);

   // ADV is the one-cycle raster advance between pixels (17 fetch + eval + advance = 19)
   typedef enum logic [2:0] {IDLE, FETCH, EVAL, ADV, EMIT, DONE} state_t;

   localparam logic [31:0] ARC_MASK = (32'd1 << ARC_LEN) - 32'd1;

   state_t                 state, state_nxt;
   logic [XW-1:0]          mx, cx;
   logic [YW-1:0]          my, cy;
   logic [PIXEL_DEPTH-1:0] thr;
   logic [4:0]             cnt;
   logic [PIXEL_DEPTH-1:0] samp [16];
   logic [PIXEL_DEPTH-1:0] ring [16];
   logic [PIXEL_DEPTH-1:0] center;
   logic [15:0]            bright, dark;
   logic                   bright_arc, dark_arc, is_corner;
   logic                   last_col, last_pix;
   logic [5:0]             ofs;

   // {dx, dy} in 3-bit two's complement for ring index 0..15
   function automatic logic [5:0] ring_ofs(input logic [3:0] idx);
      case (idx)
         4'd0:    ring_ofs = 6'b000_101;
         4'd1:    ring_ofs = 6'b001_101;
         4'd2:    ring_ofs = 6'b010_110;
         4'd3:    ring_ofs = 6'b011_111;
         4'd4:    ring_ofs = 6'b011_000;
         4'd5:    ring_ofs = 6'b011_001;
         4'd6:    ring_ofs = 6'b010_010;
         4'd7:    ring_ofs = 6'b001_011;
         4'd8:    ring_ofs = 6'b000_011;
         4'd9:    ring_ofs = 6'b111_011;
         4'd10:   ring_ofs = 6'b110_010;
         4'd11:   ring_ofs = 6'b101_001;
         4'd12:   ring_ofs = 6'b101_000;
         4'd13:   ring_ofs = 6'b101_111;
         4'd14:   ring_ofs = 6'b110_110;
         default: ring_ofs = 6'b111_101;
      endcase
   endfunction

   function automatic logic has_arc(input logic [15:0] m);
      logic [31:0] d;
      logic        hit;
      d   = {m, m};
      hit = 1'b0;
      for (int unsigned s = 0; s < 16; s++) begin
         if (((d >> s) & ARC_MASK) == ARC_MASK) hit = 1'b1;
      end
      return hit;
   endfunction

   // ring index 15 is still on rdat during EVAL
   always_comb begin
      for (int unsigned i = 0; i < 15; i++) ring[i] = samp[i+1];
      ring[15] = rdat;
      center   = samp[0];
   end

   always_comb begin
      bright = '0;
      dark   = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         bright[i] = {1'b0, ring[i]} > ({1'b0, center} + {1'b0, thr});
         dark[i]   = ({1'b0, ring[i]} + {1'b0, thr}) < {1'b0, center};
      end
   end

   assign bright_arc = has_arc(bright);
   assign dark_arc   = has_arc(dark);
   assign is_corner  = bright_arc | dark_arc;

   assign last_col = (cx == mx - XW'(3));
   assign last_pix = last_col && (cy == my - YW'(3));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (new_trans) begin
               if ((32'(max_x) < 32'd6) || (32'(max_y) < 32'd6)) state_nxt = DONE;
               else                                                state_nxt = FETCH;
            end
         end
         FETCH:   if (cnt == 5'd16) state_nxt = EVAL;
         EVAL:    state_nxt = is_corner ? EMIT : ADV;
         EMIT:    if (corner_ready) state_nxt = ADV;
         ADV:     state_nxt = last_pix ? DONE : FETCH;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= IDLE;
         mx       <= '0;
         my       <= '0;
         thr      <= '0;
         cx       <= '0;
         cy       <= '0;
         cnt      <= '0;
         corner_x <= '0;
         corner_y <= '0;
         for (int unsigned i = 0; i < 16; i++) samp[i] <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (new_trans) begin
                  mx  <= max_x;
                  my  <= max_y;
                  thr <= threshold;
                  cx  <= XW'(3);
                  cy  <= YW'(3);
                  cnt <= '0;
               end
            end
            FETCH: begin
               if (cnt != 5'd0) samp[4'(cnt - 5'd1)] <= rdat;
               cnt <= cnt + 5'd1;
            end
            EVAL: begin
               cnt <= '0;
               if (is_corner) begin
                  corner_x <= cx;
                  corner_y <= cy;
               end
            end
            ADV: begin
               if (!last_pix) begin
                  if (last_col) begin
                     cx <= XW'(3);
                     cy <= cy + YW'(1);
                  end else begin
                     cx <= cx + XW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef FAST_SCORE_EN
   logic [SW-1:0] score_b, score_d;

   always_comb begin
      score_b = '0;
      score_d = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (bright[i]) score_b = score_b + SW'(ring[i]) - SW'(center) - SW'(thr);
         if (dark[i])   score_d = score_d + SW'(center) - SW'(ring[i]) - SW'(thr);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)                         corner_score <= '0;
      else if (state == EVAL && is_corner) corner_score <= bright_arc ? score_b : score_d;
   end
`else
   assign corner_score = '0;
`endif

   assign ofs          = (cnt == 5'd0) ? 6'b000_000 : ring_ofs(4'(cnt - 5'd1));
   assign ren          = (state == FETCH);
   assign x_addr       = ren ? ({1'b0, cx} + {{(XW-2){ofs[5]}}, ofs[5:3]}) : '0;
   assign y_addr       = ren ? ({1'b0, cy} + {{(YW-2){ofs[2]}}, ofs[2:0]}) : '0;
   assign corner_valid = (state == EMIT);
   assign fast_done    = (state == DONE);

endmodule
